pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_seq_if.sv | 35 +++
 rtl/pc_ret_stack.sv | 50 +++++
 rtl/pc_seq.sv | 138 +++++++++++++
 tb/tb_pc_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM encoding and
// default widths.
package pc_seq_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int STK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_STALL,
    ST_ERR
  } state_t;

endpackage

// File: rtl/pc_seq_if.sv
// Request/control bundle between the sequencer and its environment
// (request source plus the external program counter).
interface pc_seq_if
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              start;
  logic              hold;
  logic              jump_req;
  logic              call_req;
  logic              ret_req;
  logic [ADDR_W-1:0] tgt_addr;
  logic [ADDR_W-1:0] pc_val;
  logic              pc_clr;
  logic              pc_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_din;
  logic              fetch_vld;
  logic              stk_ovf;
  logic              stk_unf;
  logic              busy;

  modport master (
    output start, hold, jump_req, call_req, ret_req, tgt_addr, pc_val,
    input  pc_clr, pc_inc, pc_load, pc_din, fetch_vld, stk_ovf, stk_unf, busy
  );

  modport slave (
    input  start, hold, jump_req, call_req, ret_req, tgt_addr, pc_val,
    output pc_clr, pc_inc, pc_load, pc_din, fetch_vld, stk_ovf, stk_unf, busy
  );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. The caller never pushes and pops in the same cycle and
// never pushes when full or pops when empty.
module pc_ret_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] sp;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push) begin
      sp <= sp + 1'b1;
    end else if (pop) begin
      sp <= sp - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointer alone defines which
  // entries are meaningful, so the array can map to plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[PW'(sp)] <= din;
    end
  end

  assign full  = (sp == CW'(DEPTH));
  assign empty = (sp == '0);
  assign top   = mem[PW'(sp - 1'b1)];

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: drives clear/increment/load of an external PC and
// manages a call/return stack with sticky overflow/underflow flags.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
) (
  input  logic     clk,
  input  logic     res,
  pc_seq_if.slave  bus
);

  state_t            state, next_state;
  logic              push, pop, stk_clr, full, empty;
  logic [ADDR_W-1:0] top, ret_addr;
  logic              set_ovf, set_unf, clr_flags;
  logic              ovf_q, unf_q;

  assign ret_addr = bus.pc_val + 1'b1;

  pc_ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (res),
    .clr   (stk_clr),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= ST_IDLE;
    else      state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    next_state    = state;
    bus.pc_clr    = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_din    = '0;
    bus.fetch_vld = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    stk_clr       = 1'b0;
    set_ovf       = 1'b0;
    set_unf       = 1'b0;
    clr_flags     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          next_state = ST_CLEAR;
          clr_flags  = 1'b1;
        end
      end
      ST_CLEAR: begin
        bus.pc_clr = 1'b1;
        stk_clr    = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        bus.fetch_vld = !bus.hold;
        if (bus.start) begin
          next_state = ST_CLEAR;
          clr_flags  = 1'b1;
        end else if (bus.hold) begin
          next_state = ST_STALL;
        end else if (bus.jump_req) begin
          bus.pc_load = 1'b1;
          bus.pc_din  = bus.tgt_addr;
        end else if (bus.call_req) begin
          if (full) begin
            set_ovf    = 1'b1;
            next_state = ST_ERR;
          end else begin
            bus.pc_load = 1'b1;
            bus.pc_din  = bus.tgt_addr;
            push        = 1'b1;
          end
        end else if (bus.ret_req) begin
          if (empty) begin
            set_unf    = 1'b1;
            next_state = ST_ERR;
          end else begin
            bus.pc_load = 1'b1;
            bus.pc_din  = top;
            pop         = 1'b1;
          end
        end else begin
          bus.pc_inc = 1'b1;
        end
      end
      ST_STALL: begin
        if (bus.start) begin
          next_state = ST_CLEAR;
          clr_flags  = 1'b1;
        end else if (!bus.hold) begin
          next_state = ST_RUN;
        end
      end
      ST_ERR: begin
        if (bus.start) begin
          next_state = ST_CLEAR;
          clr_flags  = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Flags clear as start is accepted, so they already read low during CLEAR.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr_flags) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | set_ovf;
      unf_q <= unf_q | set_unf;
    end
  end

  assign bus.stk_ovf = ovf_q;
  assign bus.stk_unf = unf_q;
  assign bus.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: models the external PC register and checks the
// sequencer's controls against hand-computed expectations.
module tb_pc_seq;

  logic        clk;
  logic        res;
  logic [15:0] pc;
  int          n_checks = 0;
  int          n_errors = 0;

  pc_seq_if #(.ADDR_W(16)) bus ();

  pc_seq #(
    .ADDR_W    (16),
    .STK_DEPTH (4)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External program counter driven by the sequencer's controls.
  always @(posedge clk or negedge res) begin
    if (!res)             pc <= 16'h0000;
    else if (bus.pc_clr)  pc <= 16'h0000;
    else if (bus.pc_load) pc <= bus.pc_din;
    else if (bus.pc_inc)  pc <= pc + 16'h0001;
  end
  assign bus.pc_val = pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic j, input logic c,
                       input logic r, input logic [15:0] t);
    bus.start    = s;
    bus.hold     = h;
    bus.jump_req = j;
    bus.call_req = c;
    bus.ret_req  = r;
    bus.tgt_addr = t;
  endtask

  task automatic ctl(input string tag, input logic e_clr, input logic e_inc,
                     input logic e_load, input logic [15:0] e_din);
    check({tag, ".clr"},  32'(bus.pc_clr),  32'(e_clr));
    check({tag, ".inc"},  32'(bus.pc_inc),  32'(e_inc));
    check({tag, ".load"}, 32'(bus.pc_load), 32'(e_load));
    check({tag, ".din"},  32'(bus.pc_din),  32'(e_din));
  endtask

  // Controls must stay mutually exclusive in every cycle.
  always begin
    @(negedge clk);
    #2;
    if (res) check("excl", 32'($onehot0({bus.pc_clr, bus.pc_inc, bus.pc_load})), 32'd1);
  end

  initial begin
    res = 1'b0;
    drive(0, 0, 0, 0, 0, 16'h0000);
    #3;
    ctl("rst", 0, 0, 0, 16'h0000);
    check("rst.fetch", 32'(bus.fetch_vld), 0);
    check("rst.busy",  32'(bus.busy), 0);
    check("rst.ovf",   32'(bus.stk_ovf), 0);
    check("rst.unf",   32'(bus.stk_unf), 0);

    @(negedge clk); res = 1'b1; drive(0, 0, 1, 0, 0, 16'h0012); #1;
    ctl("idle_jump", 0, 0, 0, 16'h0000);
    check("idle.busy", 32'(bus.busy), 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 16'h0000); #1;
    ctl("idle_start", 0, 0, 0, 16'h0000);
    @(negedge clk); drive(0, 0, 0, 0, 0, 16'h0000); #1;
    ctl("clear", 1, 0, 0, 16'h0000);
    check("clear.busy",  32'(bus.busy), 1);
    check("clear.fetch", 32'(bus.fetch_vld), 0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("inc.pc", 32'(pc), 32'(i));
      ctl("inc", 0, 1, 0, 16'h0000);
      check("inc.fetch", 32'(bus.fetch_vld), 1);
    end

    @(negedge clk); drive(0, 0, 0, 1, 0, 16'h0040); #1;
    check("call.pc", 32'(pc), 32'h3);
    ctl("call", 0, 0, 1, 16'h0040);
    @(negedge clk); drive(0, 0, 0, 0, 0, 16'h0000); #1;
    check("tgt.pc", 32'(pc), 32'h40);
    ctl("after_call", 0, 1, 0, 16'h0000);
    @(negedge clk); drive(0, 0, 0, 0, 1, 16'h0000); #1;
    check("ret.pc", 32'(pc), 32'h41);
    ctl("ret", 0, 0, 1, 16'h0004);

    @(negedge clk); drive(0, 0, 1, 1, 0, 16'h0100); #1;
    check("jc.pc", 32'(pc), 32'h4);
    ctl("jump_call", 0, 0, 1, 16'h0100);
    @(negedge clk); drive(0, 0, 1, 0, 0, 16'hFFFF); #1;
    check("jmp.pc", 32'(pc), 32'h100);
    ctl("jump", 0, 0, 1, 16'hFFFF);
    @(negedge clk); drive(0, 0, 0, 1, 0, 16'h0200); #1;
    check("callw.pc", 32'(pc), 32'hFFFF);
    ctl("call_wrap", 0, 0, 1, 16'h0200);
    @(negedge clk); drive(0, 0, 0, 0, 1, 16'h0000); #1;
    ctl("ret_wrap", 0, 0, 1, 16'h0000);

    @(negedge clk); drive(0, 0, 0, 0, 1, 16'h0000); #1;
    ctl("ret_empty", 0, 0, 0, 16'h0000);
    check("ret_empty.unf", 32'(bus.stk_unf), 0);
    @(negedge clk); drive(0, 0, 0, 0, 1, 16'h0000); #1;
    ctl("err_unf", 0, 0, 0, 16'h0000);
    check("err_unf.unf",   32'(bus.stk_unf), 1);
    check("err_unf.ovf",   32'(bus.stk_ovf), 0);
    check("err_unf.busy",  32'(bus.busy), 1);
    check("err_unf.fetch", 32'(bus.fetch_vld), 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 16'h0000); #1;
    ctl("err_start", 0, 0, 0, 16'h0000);
    @(negedge clk); drive(0, 0, 0, 0, 0, 16'h0000); #1;
    ctl("clear2", 1, 0, 0, 16'h0000);
    check("clear2.unf", 32'(bus.stk_unf), 0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(0, 0, 0, 1, 0, 16'(16'h0010 * (i + 1))); #1;
      ctl("nest", 0, 0, 1, 16'(16'h0010 * (i + 1)));
    end
    @(negedge clk); drive(0, 0, 0, 1, 0, 16'h0050); #1;
    ctl("call5", 0, 0, 0, 16'h0000);
    check("call5.ovf", 32'(bus.stk_ovf), 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 16'h0000); #1;
    ctl("err_ovf", 0, 0, 0, 16'h0000);
    check("err_ovf.ovf",   32'(bus.stk_ovf), 1);
    check("err_ovf.busy",  32'(bus.busy), 1);
    check("err_ovf.fetch", 32'(bus.fetch_vld), 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 16'h0000);
    @(negedge clk); drive(0, 0, 0, 0, 0, 16'h0000); #1;
    ctl("clear3", 1, 0, 0, 16'h0000);
    check("clear3.ovf", 32'(bus.stk_ovf), 0);
    @(negedge clk); drive(0, 0, 0, 0, 1, 16'h0000); #1;
    ctl("ret_after_clr", 0, 0, 0, 16'h0000);
    @(negedge clk); drive(1, 0, 0, 0, 0, 16'h0000);
    @(negedge clk); drive(0, 0, 0, 0, 0, 16'h0000); #1;
    ctl("clear4", 1, 0, 0, 16'h0000);

    @(negedge clk); #1;
    ctl("run4", 0, 1, 0, 16'h0000);
    @(negedge clk); drive(0, 1, 1, 0, 0, 16'h0077); #1;
    check("hold1.pc", 32'(pc), 32'h1);
    ctl("hold1", 0, 0, 0, 16'h0000);
    check("hold1.fetch", 32'(bus.fetch_vld), 0);
    @(negedge clk); drive(0, 1, 0, 0, 0, 16'h0000); #1;
    ctl("hold2", 0, 0, 0, 16'h0000);
    check("hold2.busy", 32'(bus.busy), 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 16'h0000); #1;
    ctl("stall_rel", 0, 0, 0, 16'h0000);
    check("stall_rel.pc", 32'(pc), 32'h1);
    @(negedge clk); drive(0, 0, 1, 0, 0, 16'h0033); #1;
    check("resume.pc", 32'(pc), 32'h1);
    ctl("resume", 0, 0, 1, 16'h0033);
    #2 res = 1'b0; #1;
    ctl("async_rst", 0, 0, 0, 16'h0000);
    check("async_rst.busy",  32'(bus.busy), 0);
    check("async_rst.fetch", 32'(bus.fetch_vld), 0);
    @(negedge clk); res = 1'b1; #1;
    ctl("post_rst", 0, 0, 0, 16'h0000);
    check("post_rst.busy", 32'(bus.busy), 0);
    @(negedge clk); #1;
    ctl("post_rst2", 0, 0, 0, 16'h0000);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
